// File: rtl/switch_cfg_regs.sv
// switch_cfg_regs: slave side of the switch memory-config interface.
// Accepts mem_sel_en/mem_addr/mem_wr_rd_s requests from the config master,
// holds the per-port destination-address registers and returns read data
// with a one-cycle mem_ack after ACK_DELAY wait cycles.
// Ports:
//   clk, rst_n      clock (rising edge), async active-low reset
//   mem_sel_en      request valid, held by master until mem_ack
//   mem_addr        register address (0..NUM_PORTS-1 port regs, 8'hFF ID)
//   mem_wr_data     write data
//   mem_wr_rd_s     1 = write, 0 = read
//   mem_rd_data     registered read data, held until the next read
//   mem_ack         registered one-cycle completion pulse
//   port_addr_o     port i register on bits [8*i+7 : 8*i]
//   cfg_upd_o       one-cycle pulse when a port register is written
module switch_cfg_regs #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ACK_DELAY = 1,
  parameter logic [7:0]  ID_VALUE  = 8'h5A
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mem_sel_en,
  input  logic [7:0]             mem_addr,
  input  logic [7:0]             mem_wr_data,
  input  logic                   mem_wr_rd_s,
  output logic [7:0]             mem_rd_data,
  output logic                   mem_ack,
  output logic [8*NUM_PORTS-1:0] port_addr_o,
  output logic                   cfg_upd_o
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 8;
  localparam logic [7:0]  ID_ADDR = 8'hFF;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       wr;
  } req_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  req_t               req_q;
  req_t               live_req_c;
  req_t               cmt_req_c;
  logic               accept_c;
  logic               commit_c;
  logic               wr_hit_c;
  logic               rd_c;
  logic [DATA_W-1:0]  rd_val_c;
  logic [DATA_W-1:0]  port_reg [NUM_PORTS];

  assign live_req_c = '{addr: mem_addr, data: mem_wr_data, wr: mem_wr_rd_s};

  // State and wait-counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (mem_sel_en) begin
          if (ACK_DELAY == 0) begin
            state_nxt = S_ACK;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_W'(ACK_DELAY - 1);
          end
        end
      end
      S_WAIT: begin
        if (!mem_sel_en) begin
          state_nxt = S_IDLE;
        end else if (cnt == '0) begin
          state_nxt = S_ACK;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_ACK:   state_nxt = S_HOLD;
      S_HOLD:  if (!mem_sel_en) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output/commit decode; with no wait cycles the commit happens on the accept
  // edge itself, so the live inputs are used instead of the captured copy.
  always_comb begin
    accept_c  = (state == S_IDLE) && mem_sel_en;
    cmt_req_c = (state == S_IDLE) ? live_req_c : req_q;
    commit_c  = (state_nxt == S_ACK) && (state != S_ACK);
    wr_hit_c  = commit_c && cmt_req_c.wr && (cmt_req_c.addr < 8'(NUM_PORTS));
    rd_c      = commit_c && !cmt_req_c.wr;
    rd_val_c  = '0;
    if (cmt_req_c.addr == ID_ADDR) begin
      rd_val_c = ID_VALUE;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (cmt_req_c.addr == 8'(i)) rd_val_c = port_reg[i];
    end
  end

  // Request capture, register file and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q       <= '0;
      mem_ack     <= 1'b0;
      cfg_upd_o   <= 1'b0;
      mem_rd_data <= '0;
      for (int i = 0; i < NUM_PORTS; i++) port_reg[i] <= '0;
    end else begin
      if (accept_c) req_q <= live_req_c;
      mem_ack   <= commit_c;
      cfg_upd_o <= wr_hit_c;
      if (rd_c) mem_rd_data <= rd_val_c;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (wr_hit_c && (cmt_req_c.addr == 8'(i))) port_reg[i] <= cmt_req_c.data;
      end
    end
  end

  // Flatten port registers onto the core-facing bus
  always_comb begin
    port_addr_o = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_addr_o[8*i +: 8] = port_reg[i];
    end
  end

endmodule
